// File: rtl/uart_defs.sv
// Shared definitions for the UART transmit scheduler.
package uart_defs;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam int   WIDTH_DEF = 8;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  // Launch timeout counter width; holds any TIMEOUT up to 15.
  localparam int   CNT_W     = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // Scan offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources.
module uart_tx_sched
  import uart_defs::*;
#(
  parameter  int Width   = WIDTH_DEF,
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 4,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [N_REQ-1:0]       Req_Valid,
  input  logic [N_REQ*Width-1:0] Req_Data,
  input  logic [N_REQ-1:0]       Req_Par_En,
  input  logic [N_REQ-1:0]       Req_Par_Typ,
  output logic [N_REQ-1:0]       Req_Ready,
  input  logic                   Tx_Busy,
  output logic                   Tx_Data_Valid,
  output logic [Width-1:0]       Tx_P_Data,
  output logic                   Tx_Parity_En,
  output logic                   Tx_Parity_Typ,
  output logic                   Done,
  output logic                   Err,
  output logic [IDX_W-1:0]       Cur_Id
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, arb_idx;
  logic [N_REQ-1:0] arb_gnt;
  logic             arb_any, grant;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             done_set, err_set;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (Req_Valid),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign cnt_inc = cnt + 1'b1;

  // Next-state logic. Grants are held off while Done/Err are showing so a
  // completion pulse never coincides with Req_Ready; Rst gates the grant so
  // Req_Ready is quiet during reset.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Rst && arb_any && !Tx_Busy && !Done && !Err) begin
          grant     = 1'b1;
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (Tx_Busy) begin
          state_nxt = ST_WAIT_DONE;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            err_set   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!Tx_Busy) begin
          done_set  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign Req_Ready = grant ? arb_gnt : '0;

  // State and timeout counter.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Frame registers: latched on grant and held for the whole frame so the
  // transmitter sees stable data/parity; status pulses are registered.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ptr           <= '0;
      Cur_Id        <= '0;
      Tx_P_Data     <= '0;
      Tx_Parity_En  <= 1'b0;
      Tx_Parity_Typ <= PAR_EVEN;
      Tx_Data_Valid <= 1'b0;
      Done          <= 1'b0;
      Err           <= 1'b0;
    end else begin
      Tx_Data_Valid <= grant;
      Done          <= done_set;
      Err           <= err_set;
      if (grant) begin
        Cur_Id        <= arb_idx;
        ptr           <= (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        Tx_P_Data     <= Req_Data[int'(arb_idx)*Width +: Width];
        Tx_Parity_En  <= Req_Par_En[arb_idx];
        Tx_Parity_Typ <= Req_Par_Typ[arb_idx];
      end
    end
  end

endmodule
